bluetooth_decoder: RTL

- Receive-side counterpart of bluetooth_encoder: assembles ASCII response lines arriving byte-by-byte from the BLE module's UART receiver into a packed 144-bit word.
- Classifies each line into a 4-bit response code and pulses done, so the host FSM can check results of commands issued via the encoder.
- Sits between the UART RX byte interface and the host control FSM.

---
 rtl/bluetooth_decoder.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/bluetooth_decoder.sv
// Assembles CR/LF-terminated UART response lines into a 144-bit word and classifies them; done/outputs one cycle after LF.
// No backpressure: a byte can be accepted every cycle. Optional inter-byte timeout under BT_DECODER_TIMEOUT_EN.
module bluetooth_decoder #(
  parameter int MAX_BYTES      = 18,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             rx_data,
  input  logic                   rx_valid,
  output logic [8*MAX_BYTES-1:0] output_data,
  output logic [4:0]             byte_count,
  output logic [3:0]             response_type,
  output logic                   done,
  output logic                   overflow,
  output logic                   timeout,
  output logic                   busy
);

  typedef enum logic [1:0] {IDLE, COLLECT, DISCARD} state_t;

  state_t state_q, state_d;

  logic [7:0]             buffer [MAX_BYTES];
  logic [4:0]             count;
  logic [8*MAX_BYTES-1:0] line_word;
  logic [3:0]             line_type;
  logic                   is_cr, is_lf, is_pay;
  logic                   to_fire;

  assign is_cr  = rx_valid && (rx_data == 8'h0D);
  assign is_lf  = rx_valid && (rx_data == 8'h0A);
  assign is_pay = rx_valid && !is_cr && !is_lf;

  function automatic logic [3:0] classify(input logic [7:0] b0, input logic [7:0] b1,
                                          input logic [7:0] b2, input logic [4:0] n);
    logic [3:0] r;
    r = 4'hF;
    if (n >= 5'd3 && {b0, b1, b2} == "AOK")      r = 4'd1;
    else if (n >= 5'd3 && {b0, b1, b2} == "ERR") r = 4'd2;
    else if (n >= 5'd3 && {b0, b1, b2} == "CMD") r = 4'd3;
    else if (n >= 5'd3 && {b0, b1, b2} == "END") r = 4'd4;
    else if (n >= 5'd1 && b0 == "%")             r = 4'd5;
    return r;
  endfunction

  // Slots at or beyond count hold stale bytes from older lines; mask them out.
  always_comb begin
    line_word = '0;
    for (int i = 0; i < MAX_BYTES; i++) begin
      if (i < int'(count)) line_word[8*(MAX_BYTES-i)-1 -: 8] = buffer[i];
    end
  end

  assign line_type = classify(buffer[0], buffer[1], buffer[2], count);

`ifdef BT_DECODER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] to_cnt;

  assign to_fire = (state_q != IDLE) && !rx_valid && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   to_cnt <= '0;
    else if (state_q == IDLE || rx_valid || to_fire) to_cnt <= '0;
    else                                          to_cnt <= to_cnt + 1'b1;
  end
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
  assign to_fire = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (is_pay) state_d = COLLECT;
      COLLECT: begin
        if (is_lf)                                    state_d = IDLE;
        else if (is_pay && count == 5'(MAX_BYTES))    state_d = DISCARD;
        else if (to_fire)                             state_d = IDLE;
      end
      DISCARD: if (is_lf || to_fire) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_BYTES; i++) buffer[i] <= '0;
      count         <= '0;
      output_data   <= '0;
      byte_count    <= '0;
      response_type <= '0;
      done          <= 1'b0;
      overflow      <= 1'b0;
      timeout       <= 1'b0;
    end else begin
      done <= 1'b0;
      if (to_fire) begin
        timeout <= 1'b1;
        count   <= '0;
      end
      case (state_q)
        IDLE: begin
          if (is_pay) begin
            buffer[0] <= rx_data;
            count     <= 5'd1;
          end
        end
        COLLECT: begin
          if (is_lf) begin
            output_data   <= line_word;
            byte_count    <= count;
            response_type <= line_type;
            overflow      <= 1'b0;
            timeout       <= 1'b0;
            done          <= 1'b1;
            count         <= '0;
          end else if (is_pay) begin
            if (count < 5'(MAX_BYTES)) begin
              buffer[count] <= rx_data;
              count         <= count + 5'd1;
            end else begin
              overflow <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
